// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/LSU write-back handshake and register-file write port bundle
interface writeback_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2
);
    localparam int PW = $clog2(FIFO_DEPTH + 1);
    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]     alu_data;
    logic                      lsu_valid;
    logic                      lsu_ready;
    logic [REG_ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0]     lsu_data;
    logic                      alu_hold;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [PW-1:0]             lsu_pending;
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready, alu_hold, wb_en, wb_addr, wb_data, lsu_pending
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output lsu_ready, alu_hold, wb_en, wb_addr, wb_data, lsu_pending
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: ALU-priority merge of ALU and buffered LSU results onto one register-file write port
module writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_arbiter_if.slave   bus
);
    localparam int PW   = $clog2(FIFO_DEPTH + 1);
    localparam int PTRW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    logic [REG_ADDR_WIDTH-1:0] rd_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             cnt_q, cnt_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d, sel_rd;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d, sel_data;
    logic                      full, empty, pop, bypass, push, sel_valid;
    assign full   = cnt_q == PW'(FIFO_DEPTH);
    assign empty  = cnt_q == '0;
    assign pop    = !bus.alu_valid && !empty;
    assign bypass = !bus.alu_valid && empty && bus.lsu_valid;
    assign push   = bus.lsu_valid && !full && !bypass && (bus.lsu_rd != '0);
    assign bus.lsu_ready   = !full;
    assign bus.alu_hold    = starve_q == SW'(STARVE_LIMIT);
    assign bus.lsu_pending = cnt_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    // Pick the winning source, then derive write-back, FIFO and starvation next state
    always_comb begin
        sel_valid = bus.alu_valid || pop || bypass;
        sel_rd    = bus.alu_valid ? bus.alu_rd : pop ? rd_mem_q[rd_ptr_q] : bus.lsu_rd;
        sel_data  = bus.alu_valid ? bus.alu_data : pop ? data_mem_q[rd_ptr_q] : bus.lsu_data;
        wb_en_d   = sel_valid && (sel_rd != '0);
        wb_addr_d = wb_en_d ? sel_rd : wb_addr_q;
        wb_data_d = wb_en_d ? sel_data : wb_data_q;
        cnt_d     = cnt_q + PW'(push) - PW'(pop);
        wr_ptr_d  = !push ? wr_ptr_q : (wr_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d  = !pop ? rd_ptr_q : (rd_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        starve_d  = (empty || pop) ? '0 : (bus.alu_valid && !bus.alu_hold) ? starve_q + 1'b1 : starve_q;
    end
    // Control and write-back registers; reset drops any buffered or pending write at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end
    // Buffer storage needs no reset; occupancy alone says which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= bus.lsu_rd;
            data_mem_q[wr_ptr_q] <= bus.lsu_data;
        end
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges integer write-back traffic from the single-cycle ALU path and the variable-latency load/store unit (LSU) onto the register file's single write port (`writeEnable` / `addr_write` / `write_data`). It sits between the execute/memory stages and the register file. ALU results always win arbitration. LSU results are buffered in a small FIFO and drained in cycles the ALU leaves free. A starvation counter forces the ALU issue logic to yield so that pending loads cannot wait indefinitely.

## Interface

Parameters:
- `DATA_WIDTH`, 32: write-back data width.
- `REG_ADDR_WIDTH`, 5: destination register index width.
- `FIFO_DEPTH`, 2: LSU result buffer entries; must be ≥1.
- `STARVE_LIMIT`, 4: consecutive denied-pop cycles before `alu_hold` asserts; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `alu_valid`, in, 1: ALU result present this cycle; no backpressure, always consumed.
- `alu_rd`, in, REG_ADDR_WIDTH: ALU destination register.
- `alu_data`, in, DATA_WIDTH: ALU result.
- `lsu_valid`, in, 1: LSU result offered.
- `lsu_ready`, out, 1: LSU result accepted this cycle when high with `lsu_valid`.
- `lsu_rd`, in, REG_ADDR_WIDTH: LSU destination register.
- `lsu_data`, in, DATA_WIDTH: LSU load data.
- `alu_hold`, out, 1: upstream must not issue an ALU result next cycle.
- `wb_en`, out, 1: drives register file `writeEnable`.
- `wb_addr`, out, REG_ADDR_WIDTH: drives `addr_write`.
- `wb_data`, out, DATA_WIDTH: drives `write_data`.
- `lsu_pending`, out, clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation

- Priority each cycle N, in order:
  - `alu_valid`: select the ALU result.
  - Else, FIFO non-empty: pop the head and select it.
  - Else, `lsu_valid`: bypass and select the LSU input directly; no push.
  - Else: no write.
- `lsu_ready` = !full. This is combinational from occupancy only, not from the current cycle's pop.
- Push happens when `lsu_valid && lsu_ready` and the bypass was not taken.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- FIFO order is strict FIFO. Read/write pointers wrap modulo FIFO_DEPTH.
- rd == 0 from either source: the result is accepted (handshake completes, no push) but produces `wb_en`=0.
  - An x0 result selected via ALU or bypass still consumes that cycle's slot.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle where FIFO is non-empty and `alu_valid`=1.
  - Clears on any pop and whenever the FIFO is empty.
- `alu_hold` = (counter == STARVE_LIMIT), combinational from the counter.
- If upstream violates `alu_hold` and asserts `alu_valid`, the ALU still wins; no result is dropped and the counter stays saturated.

## Timing

- Selection in cycle N appears on `wb_en`/`wb_addr`/`wb_data` registered in cycle N+1. The register file writes at the end of N+1.
- Latency:
  - ALU: 1 cycle.
  - LSU bypass: 1 cycle.
  - LSU buffered: 1 cycle after the pop cycle.
- `wb_addr`/`wb_data` hold their last value when `wb_en`=0.
- Reset values: `wb_en`=0, `wb_addr`=0, `wb_data`=0, occupancy 0, `lsu_ready`=1, `alu_hold`=0, counter 0.
- Reset mid-operation discards all buffered LSU results and any registered write. `wb_en` deasserts asynchronously.
- Full FIFO with simultaneous pop: `lsu_ready` stays 0 that cycle; the freed slot is usable next cycle.

## Test plan

- Reset, then ALU rd=5 data=0xDEADBEEF in cycle 1: cycle 2 shows `wb_en`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF; cycle 3 shows `wb_en`=0.
- Idle ALU, LSU rd=7 data=0x12345678: `lsu_ready`=1, bypass; next cycle `wb_en`=1, addr 7; `lsu_pending` stays 0.
- ALU valid continuously; LSU pushes rd=8 then rd=9: `lsu_pending` goes 1 then 2; `lsu_ready`=0 once full. When ALU stops, the bench sees writes to 8 then 9 on consecutive cycles.
- ALU valid continuously with 1 LSU entry pending, STARVE_LIMIT=4: `alu_hold` rises after 4 denied cycles. Upstream drops `alu_valid`; the entry pops, and `alu_hold` and the counter clear the next cycle.
- ALU rd=0 data=0xFFFFFFFF and LSU rd=0 bypass: handshakes complete, `wb_en` stays 0, and register x0 still reads 0.
- FIFO holding 2 entries, assert `reset` asynchronously mid-cycle: `wb_en`=0 immediately, `lsu_pending`=0, `lsu_ready`=1; no stale write appears after reset release.
